// File: rtl/parser_pkg.sv
// Shared types and constants for the ingress segment splitter.
// Optional statistics are enabled with the SEG_SPLIT_STATS_EN macro.
package parser_pkg;

    localparam int unsigned AXIS_DATA_W  = 512;
    localparam int unsigned AXIS_KEEP_W  = AXIS_DATA_W / 8;
    localparam int unsigned AXIS_TUSER_W = 128;
    localparam int unsigned VLANID_W     = 12;
    localparam int unsigned HDR_SEG_W    = 2 * AXIS_DATA_W;
    localparam int unsigned STAT_W       = 32;

    // VLAN ID sits in TCI bytes 14 (low nibble) and 15, byte-lane order
    localparam int unsigned VLAN_HI_LSB = 112;
    localparam int unsigned VLAN_HI_W   = 4;
    localparam int unsigned VLAN_LO_LSB = 120;
    localparam int unsigned VLAN_LO_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEG1  = 2'd1,
        FLUSH = 2'd2
    } seg_state_e;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0]  tdata;
        logic [AXIS_KEEP_W-1:0]  tkeep;
        logic [AXIS_TUSER_W-1:0] tuser;
        logic                    tlast;
    } axis_beat_t;

    function automatic logic [VLANID_W-1:0] vlan_from_beat(input logic [AXIS_DATA_W-1:0] beat);
        return {beat[VLAN_HI_LSB +: VLAN_HI_W], beat[VLAN_LO_LSB +: VLAN_LO_W]};
    endfunction

endpackage

// File: rtl/parser_seg_splitter_if.sv
// Bus bundle of the segment splitter: AXIS ingress, packet FIFO write side,
// header segment to the parser and VLAN ID to the pipeline.
interface parser_seg_splitter_if;
    import parser_pkg::*;

    logic [AXIS_DATA_W-1:0]  s_axis_tdata;
    logic [AXIS_KEEP_W-1:0]  s_axis_tkeep;
    logic [AXIS_TUSER_W-1:0] s_axis_tuser;
    logic                    s_axis_tvalid;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;

    logic [AXIS_DATA_W-1:0]  pkt_fifo_tdata;
    logic [AXIS_KEEP_W-1:0]  pkt_fifo_tkeep;
    logic [AXIS_TUSER_W-1:0] pkt_fifo_tuser;
    logic                    pkt_fifo_tlast;
    logic                    pkt_fifo_wr_en;
    logic                    pkt_fifo_ready;

    logic [HDR_SEG_W-1:0]    hdr_segs;
    logic [AXIS_TUSER_W-1:0] hdr_tuser;
    logic                    hdr_valid;
    logic                    hdr_ready;

    logic [VLANID_W-1:0]     vlan_id;
    logic                    vlan_valid;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output pkt_fifo_tdata, pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_wr_en,
        input  pkt_fifo_ready,
        output hdr_segs, hdr_tuser, hdr_valid,
        input  hdr_ready,
        output vlan_id, vlan_valid
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  pkt_fifo_tdata, pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_wr_en,
        output pkt_fifo_ready,
        input  hdr_segs, hdr_tuser, hdr_valid,
        output hdr_ready,
        input  vlan_id, vlan_valid
    );

endinterface

// File: rtl/seg_split_stats.sv
// Packet and stall counters of the segment splitter, present only with SEG_SPLIT_STATS_EN.
`ifdef SEG_SPLIT_STATS_EN
module seg_split_stats
    import parser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pkt_inc,
    input  logic              i_stall_inc,
    output logic [STAT_W-1:0] o_pkt_cnt,
    output logic [STAT_W-1:0] o_stall_cnt
);

    logic [STAT_W-1:0] r_pkt_cnt;
    logic [STAT_W-1:0] r_stall_cnt;

    // Free-running wrap-around counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_pkt_inc)   r_pkt_cnt   <= r_pkt_cnt + STAT_W'(1);
            if (i_stall_inc) r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule
`endif

// File: rtl/parser_seg_splitter.sv
// Forwards every ingress beat to the packet FIFO and captures the first two beats as a
// header segment plus VLAN ID. SEG_SPLIT_STATS_EN adds packet/stall counters.
module parser_seg_splitter
    import parser_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int unsigned C_AXIS_TUSER_WIDTH = AXIS_TUSER_W,
    parameter int unsigned C_VLANID_WIDTH     = VLANID_W
)
(
    input  logic              axis_clk,
    input  logic              aresetn,
    parser_seg_splitter_if.slave bus
`ifdef SEG_SPLIT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_pkt_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    seg_state_e r_state;
    seg_state_e w_state_nxt;

    logic w_tready;
    logic w_accept;
    logic w_cap_seg0;
    logic w_hdr_done;
    logic w_single;

    axis_beat_t                    w_in_beat;
    axis_beat_t                    r_out_beat;
    logic                          r_wr_en;
    logic [C_AXIS_DATA_WIDTH-1:0]  r_seg0;
    logic [C_AXIS_TUSER_WIDTH-1:0] r_tuser0;

    // A pending header blocks new packets, but a packet tail always drains
    assign w_tready = bus.pkt_fifo_ready & ((r_state == FLUSH) | ~bus.hdr_valid);
    assign w_accept = bus.s_axis_tvalid & w_tready;
    assign bus.s_axis_tready = w_tready;

    assign w_in_beat = '{tdata: bus.s_axis_tdata, tkeep: bus.s_axis_tkeep,
                         tuser: bus.s_axis_tuser, tlast: bus.s_axis_tlast};

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_seg0  = 1'b0;
        w_hdr_done  = 1'b0;
        w_single    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cap_seg0 = 1'b1;
                    if (bus.s_axis_tlast) begin
                        w_hdr_done = 1'b1;
                        w_single   = 1'b1;
                    end else begin
                        w_state_nxt = SEG1;
                    end
                end
            end
            SEG1: begin
                if (w_accept) begin
                    w_hdr_done  = 1'b1;
                    w_state_nxt = bus.s_axis_tlast ? IDLE : FLUSH;
                end
            end
            FLUSH: begin
                if (w_accept && bus.s_axis_tlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Packet FIFO write path, one cycle behind acceptance
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_beat <= '0;
            r_wr_en    <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) r_out_beat <= w_in_beat;
        end
    end

    assign bus.pkt_fifo_tdata = r_out_beat.tdata;
    assign bus.pkt_fifo_tkeep = r_out_beat.tkeep;
    assign bus.pkt_fifo_tuser = r_out_beat.tuser;
    assign bus.pkt_fifo_tlast = r_out_beat.tlast;
    assign bus.pkt_fifo_wr_en = r_wr_en;

    // Header capture; a completion in the same cycle as hdr_ready keeps hdr_valid set
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_seg0         <= '0;
            r_tuser0       <= '0;
            bus.hdr_segs   <= '0;
            bus.hdr_tuser  <= '0;
            bus.hdr_valid  <= 1'b0;
            bus.vlan_id    <= '0;
            bus.vlan_valid <= 1'b0;
        end else begin
            bus.vlan_valid <= w_hdr_done;
            if (w_cap_seg0) begin
                r_seg0   <= bus.s_axis_tdata;
                r_tuser0 <= bus.s_axis_tuser;
            end
            if (w_hdr_done) begin
                bus.hdr_valid <= 1'b1;
                if (w_single) begin
                    bus.hdr_segs  <= {{C_AXIS_DATA_WIDTH{1'b0}}, bus.s_axis_tdata};
                    bus.hdr_tuser <= bus.s_axis_tuser;
                    bus.vlan_id   <= C_VLANID_WIDTH'(vlan_from_beat(bus.s_axis_tdata));
                end else begin
                    bus.hdr_segs  <= {bus.s_axis_tdata, r_seg0};
                    bus.hdr_tuser <= r_tuser0;
                    bus.vlan_id   <= C_VLANID_WIDTH'(vlan_from_beat(r_seg0));
                end
            end else if (bus.hdr_ready) begin
                bus.hdr_valid <= 1'b0;
            end
        end
    end

`ifdef SEG_SPLIT_STATS_EN
    seg_split_stats u_stats (
        .clk         (axis_clk),
        .rst_n       (aresetn),
        .i_pkt_inc   (w_accept & bus.s_axis_tlast),
        .i_stall_inc (bus.s_axis_tvalid & ~w_tready),
        .o_pkt_cnt   (stat_pkt_cnt),
        .o_stall_cnt (stat_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_parser_seg_splitter.sv
// Directed scoreboard bench for parser_seg_splitter; covers SEG_SPLIT_STATS_EN when defined.
module tb_parser_seg_splitter;
    import parser_pkg::*;

    localparam int unsigned DW = AXIS_DATA_W;
    localparam int unsigned KW = AXIS_KEEP_W;
    localparam int unsigned UW = AXIS_TUSER_W;
    localparam int unsigned VW = VLANID_W;

    logic axis_clk = 1'b0;
    logic aresetn;
    always #5 axis_clk = ~axis_clk;

    parser_seg_splitter_if bus ();

`ifdef SEG_SPLIT_STATS_EN
    logic [31:0] stat_pkt_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    parser_seg_splitter dut (
        .axis_clk (axis_clk),
        .aresetn  (aresetn),
        .bus      (bus)
`ifdef SEG_SPLIT_STATS_EN
        ,
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            cyc;
    } fifo_exp_t;

    typedef struct {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic [UW-1:0] u;
        logic [VW-1:0] v;
        int            cyc;
    } hdr_exp_t;

    fifo_exp_t fq[$];
    hdr_exp_t  hq[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_pkts   = 0;
    int exp_stalls = 0;
    logic prev_vv = 1'b0;

    logic [DW-1:0] pd [8];
    logic [KW-1:0] pk [8];
    logic [UW-1:0] pu [8];
    logic [DW-1:0] a_beat0;

    always @(posedge axis_clk) cyc++;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model_vlan(input logic [DW-1:0] b);
        logic [7:0] byte14;
        logic [7:0] byte15;
        byte14 = b[14*8 +: 8];
        byte15 = b[15*8 +: 8];
        return {byte14[3:0], byte15};
    endfunction

    task automatic gen_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 16; w++) pd[i][32*w +: 32] = $urandom;
            pk[i] = '1;
            pu[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        pk[n-1] = {$urandom, $urandom} | 64'h1;
    endtask

    task automatic drive_beat(input int i, input logic last, output int acc_cyc);
        int  budget;
        bit  done;
        budget  = 0;
        done    = 1'b0;
        acc_cyc = 0;
        bus.s_axis_tdata  = pd[i];
        bus.s_axis_tkeep  = pk[i];
        bus.s_axis_tuser  = pu[i];
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        while (!done) begin
            @(negedge axis_clk);
            if (bus.s_axis_tready === 1'b1) begin
                acc_cyc = cyc;
                fq.push_back('{d: pd[i], k: pk[i], u: pu[i], l: last, cyc: cyc});
                if (last) exp_pkts++;
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_timeout: beat %0d never accepted", i);
                    $display("[TB] %0d tests run, %0d failed", tests, fails);
                    $fatal(1, "aborting run");
                end
            end
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int n);
        int acc;
        for (int i = 0; i < n; i++) begin
            drive_beat(i, (i == n - 1), acc);
            if (n == 1)
                hq.push_back('{lo: pd[0], hi: '0, u: pu[0], v: model_vlan(pd[0]), cyc: acc});
            else if (i == 1)
                hq.push_back('{lo: pd[0], hi: pd[1], u: pu[0], v: model_vlan(pd[0]), cyc: acc});
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Output monitor: pops the scoreboards on every FIFO write and header completion
    always @(negedge axis_clk) begin
        if (aresetn === 1'b1) begin
            if (bus.s_axis_tvalid === 1'b1 && bus.s_axis_tready === 1'b0) exp_stalls++;
            if (bus.pkt_fifo_wr_en === 1'b1) begin
                if (fq.size() == 0) begin
                    chk("wr_extra", 512'(bus.pkt_fifo_wr_en), 512'(0));
                end else begin
                    fifo_exp_t e;
                    e = fq.pop_front();
                    chk("fifo_tdata", bus.pkt_fifo_tdata, e.d);
                    chk("fifo_tkeep", 512'(bus.pkt_fifo_tkeep), 512'(e.k));
                    chk("fifo_tuser", 512'(bus.pkt_fifo_tuser), 512'(e.u));
                    chk("fifo_tlast", 512'(bus.pkt_fifo_tlast), 512'(e.l));
                    chk("fifo_latency", 512'(cyc), 512'(e.cyc + 1));
                end
            end
            if (bus.vlan_valid === 1'b1) begin
                chk("vlan_single_pulse", 512'(prev_vv), 512'(0));
                chk("hdr_valid_with_vlan", 512'(bus.hdr_valid), 512'(1));
                if (hq.size() == 0) begin
                    chk("hdr_extra", 512'(bus.vlan_valid), 512'(0));
                end else begin
                    hdr_exp_t h;
                    h = hq.pop_front();
                    chk("hdr_seg_lo", bus.hdr_segs[511:0], h.lo);
                    chk("hdr_seg_hi", bus.hdr_segs[1023:512], h.hi);
                    chk("hdr_tuser", 512'(bus.hdr_tuser), 512'(h.u));
                    chk("vlan_id", 512'(bus.vlan_id), 512'(h.v));
                    chk("hdr_latency", 512'(cyc), 512'(h.cyc + 1));
                end
            end
            prev_vv = bus.vlan_valid;
        end else begin
            prev_vv = 1'b0;
        end
    end

    initial begin
        bus.s_axis_tdata   = '0;
        bus.s_axis_tkeep   = '0;
        bus.s_axis_tuser   = '0;
        bus.s_axis_tvalid  = 1'b0;
        bus.s_axis_tlast   = 1'b0;
        bus.pkt_fifo_ready = 1'b1;
        bus.hdr_ready      = 1'b1;
        aresetn            = 1'b0;
        repeat (2) @(posedge axis_clk);
        #1;

        // Reset state
        chk("rst_wr_en", 512'(bus.pkt_fifo_wr_en), 512'(0));
        chk("rst_hdr_valid", 512'(bus.hdr_valid), 512'(0));
        chk("rst_vlan_valid", 512'(bus.vlan_valid), 512'(0));
        chk("rst_vlan_id", 512'(bus.vlan_id), 512'(0));
        chk("rst_hdr_lo", bus.hdr_segs[511:0], 512'(0));
        chk("rst_tready_eq", 512'(bus.s_axis_tready), 512'(1));
        bus.pkt_fifo_ready = 1'b0;
        #1;
        chk("rst_tready_blocked", 512'(bus.s_axis_tready), 512'(0));
        bus.pkt_fifo_ready = 1'b1;
        @(negedge axis_clk);
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;

        // Single-beat packet with TCI bytes 0x0123
        gen_pkt(1);
        pk[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        pd[0][119:112] = 8'h01;
        pd[0][127:120] = 8'h23;
        send_pkt(1);
        repeat (3) @(posedge axis_clk);
        #1;
        chk("t1_vlan_const", 512'(bus.vlan_id), 512'(12'h123));
        chk("t1_vlan_pulse_gone", 512'(bus.vlan_valid), 512'(0));
        chk("t1_hdr_consumed", 512'(bus.hdr_valid), 512'(0));

        // Five-beat packet, all ready
        gen_pkt(5);
        send_pkt(5);
        repeat (3) @(posedge axis_clk);
        #1;

        // Two back-to-back 3-beat packets with the parser holding off
        bus.hdr_ready = 1'b0;
        fork
            begin
                gen_pkt(3);
                a_beat0 = pd[0];
                send_pkt(3);
                gen_pkt(3);
                send_pkt(3);
            end
            begin
                repeat (10) @(posedge axis_clk);
                #1;
                chk("t3_b_stalled", 512'(bus.s_axis_tready), 512'(0));
                chk("t3_b_waiting", 512'(bus.s_axis_tvalid), 512'(1));
                chk("t3_hdr_held", 512'(bus.hdr_valid), 512'(1));
                chk("t3_hdr_is_a", bus.hdr_segs[511:0], a_beat0);
                chk("t3_a_drained", 512'(fq.size()), 512'(0));
                bus.hdr_ready = 1'b1;
            end
        join
        repeat (3) @(posedge axis_clk);
        #1;

        // Packet FIFO backpressure toggling during a 4-beat packet
        gen_pkt(4);
        fork
            send_pkt(4);
            begin
                for (int t = 0; t < 8; t++) begin
                    bus.pkt_fifo_ready = (t % 2 == 0);
                    @(negedge axis_clk);
                    chk("t4_tready_follows", 512'(bus.s_axis_tready), 512'(bus.pkt_fifo_ready));
                    @(posedge axis_clk);
                    #1;
                end
                bus.pkt_fifo_ready = 1'b1;
            end
        join
        repeat (3) @(posedge axis_clk);
        #1;

        // Asynchronous reset while the FSM is in SEG1
        gen_pkt(3);
        begin
            int acc;
            drive_beat(0, 1'b0, acc);
        end
        bus.s_axis_tvalid = 1'b0;
        @(negedge axis_clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_wr_en_cleared", 512'(bus.pkt_fifo_wr_en), 512'(0));
        chk("t5_hdr_lo_cleared", bus.hdr_segs[511:0], 512'(0));
        chk("t5_vlan_cleared", 512'(bus.vlan_id), 512'(0));
        chk("t5_hdr_valid_cleared", 512'(bus.hdr_valid), 512'(0));
        exp_pkts   = 0;
        exp_stalls = 0;
        @(negedge axis_clk);
        #2;
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;
        gen_pkt(2);
        send_pkt(2);
        gen_pkt(1);
        send_pkt(1);
        repeat (4) @(posedge axis_clk);
        #1;

        chk("fifo_queue_drained", 512'(fq.size()), 512'(0));
        chk("hdr_queue_drained", 512'(hq.size()), 512'(0));

`ifdef SEG_SPLIT_STATS_EN
        chk("stat_pkt_cnt", 512'(stat_pkt_cnt), 512'(exp_pkts));
        chk("stat_stall_cnt", 512'(stat_stall_cnt), 512'(exp_stalls));
        @(negedge axis_clk);
        dut.u_stats.r_pkt_cnt = 32'hFFFF_FFFF;
        @(posedge axis_clk);
        #1;
        gen_pkt(1);
        send_pkt(1);
        #1;
        chk("stat_pkt_wrap", 512'(stat_pkt_cnt), 512'(0));
        repeat (3) @(posedge axis_clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
